// File: rtl/imc_mac_engine.sv
// ---------------------------------------------------------------------------
// imc_mac_engine
//
// In-memory-compute style multiply-accumulate engine. Holds BANKS rows of
// LANES weights (DW bits each). A run latches one operand vector and walks
// the banks in ascending order, one bank per cycle, emitting each bank's
// dot product (partial) and accumulating all partials into a running total.
//
// Configuration macro:
//   IMC_SIGNED_EN  defined   -> two's complement operands/weights/results
//                  undefined -> unsigned arithmetic (default), same widths
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   wr_en      in   write one weight row this cycle
//   wr_bank    in   [BW]        target bank of the write
//   wr_data    in   [LANES*DW]  weight row, lane l at [l*DW +: DW]
//   x_data     in   [LANES*DW]  operand vector, same packing
//   start      in   begin a MAC run (ignored while busy)
//   busy       out  high whenever the FSM is not IDLE
//   res_valid  out  one partial is presented this cycle
//   res_bank   out  [BW]  bank index of the partial
//   res_data   out  [PW]  partial dot product (holds when not valid)
//   done       out  one-cycle pulse after the last partial
//   total      out  [TW]  running / final sum of partials
//   wr_err     out  one-cycle pulse: a write was rejected last cycle
//   dbg_state  out  [2]   current FSM state (IDLE=0, COMPUTE=1, DONE=2)
//
// Handshake: start and wr_en are single-cycle requests sampled at the
// rising edge; there is no back-pressure. start is accepted only in IDLE.
// wr_en is accepted in IDLE or DONE for an in-range bank, otherwise it is
// dropped and wr_err pulses on the following cycle.
// ---------------------------------------------------------------------------
module imc_mac_engine #(
   parameter  int BANKS = 4,
   parameter  int LANES = 16,
   parameter  int DW    = 4,
   localparam int BW    = (BANKS > 1) ? $clog2(BANKS) : 1,
   localparam int PW    = 2*DW + $clog2(LANES),
   localparam int TW    = PW + $clog2(BANKS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                wr_en,
   input  logic [BW-1:0]       wr_bank,
   input  logic [LANES*DW-1:0] wr_data,
   input  logic [LANES*DW-1:0] x_data,
   input  logic                start,
   output logic                busy,
   output logic                res_valid,
   output logic [BW-1:0]       res_bank,
   output logic [PW-1:0]       res_data,
   output logic                done,
   output logic [TW-1:0]       total,
   output logic                wr_err,
   output logic [1:0]          dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COMPUTE = 2'd1,
      S_DONE    = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [BW-1:0]       cnt_q, cnt_d;
   logic [LANES*DW-1:0] x_q, x_d;
   logic [TW-1:0]       acc_q, acc_d;
   logic                res_valid_q, res_valid_d;
   logic [BW-1:0]       res_bank_q, res_bank_d;
   logic [PW-1:0]       res_data_q, res_data_d;
   logic                done_q, done_d;
   logic                wr_err_q, wr_err_d;
   logic [LANES*DW-1:0] w_q [BANKS];

   logic [LANES*DW-1:0] w_row;
   logic [PW-1:0]       partial;
   logic [PW-1:0]       xe, we;
   logic [TW-1:0]       partial_ext;
   logic                wr_bank_ok;
   logic                wr_ok;

   // ------------------------------------------------------------------
   // Weight write acceptance
   // ------------------------------------------------------------------
   assign wr_bank_ok = (int'(wr_bank) < BANKS);
   assign wr_ok      = wr_en && wr_bank_ok && (state_q != S_COMPUTE);
   assign wr_err_d   = wr_en && !wr_ok;

   // ------------------------------------------------------------------
   // Dot product of the latched operand vector with the current bank.
   // Each lane is widened to PW before multiplying so the products and
   // the lane sum are exact (sign-extended in the signed build).
   // ------------------------------------------------------------------
   assign w_row = w_q[cnt_q];

   always_comb begin
      partial = '0;
      xe      = '0;
      we      = '0;
      for (int l = 0; l < LANES; l++) begin
`ifdef IMC_SIGNED_EN
         xe = PW'($signed(x_q[l*DW +: DW]));
         we = PW'($signed(w_row[l*DW +: DW]));
`else
         xe = PW'(x_q[l*DW +: DW]);
         we = PW'(w_row[l*DW +: DW]);
`endif
         partial = partial + xe * we;
      end
   end

`ifdef IMC_SIGNED_EN
   assign partial_ext = TW'($signed(partial));
`else
   assign partial_ext = TW'(partial);
`endif

   // ------------------------------------------------------------------
   // FSM next-state and registered-output next values
   // ------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      x_d         = x_q;
      acc_d       = acc_q;
      res_valid_d = 1'b0;
      res_bank_d  = res_bank_q;
      res_data_d  = res_data_q;
      done_d      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_COMPUTE;
               x_d     = x_data;
               acc_d   = '0;
               cnt_d   = '0;
            end
         end
         S_COMPUTE: begin
            res_valid_d = 1'b1;
            res_bank_d  = cnt_q;
            res_data_d  = partial;
            acc_d       = acc_q + partial_ext;
            cnt_d       = cnt_q + BW'(1);
            if (cnt_q == BW'(BANKS-1)) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            // done is registered, so it appears one cycle after the last
            // partial, coinciding with the return to IDLE.
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         x_q         <= '0;
         acc_q       <= '0;
         res_valid_q <= 1'b0;
         res_bank_q  <= '0;
         res_data_q  <= '0;
         done_q      <= 1'b0;
         wr_err_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         x_q         <= x_d;
         acc_q       <= acc_d;
         res_valid_q <= res_valid_d;
         res_bank_q  <= res_bank_d;
         res_data_q  <= res_data_d;
         done_q      <= done_d;
         wr_err_q    <= wr_err_d;
      end
   end

   // Weight storage; a write together with start in IDLE lands before the
   // first compute cycle reads bank 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int b = 0; b < BANKS; b++) begin
            w_q[b] <= '0;
         end
      end else if (wr_ok) begin
         w_q[wr_bank] <= wr_data;
      end
   end

   assign busy      = (state_q != S_IDLE);
   assign res_valid = res_valid_q;
   assign res_bank  = res_bank_q;
   assign res_data  = res_data_q;
   assign done      = done_q;
   assign total     = acc_q;
   assign wr_err    = wr_err_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_imc_mac_engine.sv
// ---------------------------------------------------------------------------
// tb_imc_mac_engine
//
// Self-checking bench for imc_mac_engine at default parameters. Expected
// partials/banks/totals are pushed to queues when a run is started and are
// popped by a negedge monitor as the DUT presents them. Define
// IMC_SIGNED_EN for both bench and design to exercise the signed build.
// ---------------------------------------------------------------------------
module tb_imc_mac_engine;

   localparam int BANKS = 4;
   localparam int LANES = 16;
   localparam int DW    = 4;
   localparam int BW    = 2;
   localparam int PW    = 12;
   localparam int TW    = 14;

   // ---------------- clock / reset ----------------
   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                wr_en = 1'b0;
   logic [BW-1:0]       wr_bank = '0;
   logic [LANES*DW-1:0] wr_data = '0;
   logic [LANES*DW-1:0] x_data = '0;
   logic                start = 1'b0;
   logic                busy;
   logic                res_valid;
   logic [BW-1:0]       res_bank;
   logic [PW-1:0]       res_data;
   logic                done;
   logic [TW-1:0]       total;
   logic                wr_err;
   logic [1:0]          dbg_state;

   always #5 clk = ~clk;

   imc_mac_engine #(.BANKS(BANKS), .LANES(LANES), .DW(DW)) dut (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (wr_en),
      .wr_bank   (wr_bank),
      .wr_data   (wr_data),
      .x_data    (x_data),
      .start     (start),
      .busy      (busy),
      .res_valid (res_valid),
      .res_bank  (res_bank),
      .res_data  (res_data),
      .done      (done),
      .total     (total),
      .wr_err    (wr_err),
      .dbg_state (dbg_state)
   );

   // ---------------- scoreboard state ----------------
   logic [PW-1:0] exp_q  [$];
   logic [BW-1:0] expb_q [$];
   logic [TW-1:0] expt_q [$];
   int n_checks = 0;
   int n_errors = 0;
   int done_cnt = 0;
   int err_cnt  = 0;

   int mw [BANKS][LANES];
   int mx [LANES];
   int lit_p [BANKS];
   int lit_t;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   // Operand interpretation for the reference model.
   function automatic int sx(input int v);
`ifdef IMC_SIGNED_EN
      return (v >= (1 << (DW-1))) ? v - (1 << DW) : v;
`else
      return v;
`endif
   endfunction

   function automatic void push_expected(input bit lit);
      int sum;
      int p;
      sum = 0;
      for (int b = 0; b < BANKS; b++) begin
         if (lit) begin
            p = lit_p[b];
         end else begin
            p = 0;
            for (int l = 0; l < LANES; l++) p += sx(mx[l]) * sx(mw[b][l]);
         end
         sum += p;
         exp_q.push_back(PW'(p));
         expb_q.push_back(BW'(b));
      end
      expt_q.push_back(lit ? TW'(lit_t) : TW'(sum));
   endfunction

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (!rst) begin
         if (res_valid) begin
            if (exp_q.size() == 0) begin
               check_val("unexpected_partial", 32'd1, 32'd0);
            end else begin
               check_val("res_data", 32'(res_data), 32'(exp_q.pop_front()));
               check_val("res_bank", 32'(res_bank), 32'(expb_q.pop_front()));
            end
         end
         if (done) begin
            done_cnt++;
            if (expt_q.size() == 0) check_val("unexpected_done", 32'd1, 32'd0);
            else                    check_val("total", 32'(total), 32'(expt_q.pop_front()));
         end
         if (wr_err) err_cnt++;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic write_bank(input int b);
      wr_en   = 1'b1;
      wr_bank = BW'(b);
      for (int l = 0; l < LANES; l++) wr_data[l*DW +: DW] = DW'(mw[b][l]);
      @(posedge clk); #1;
      wr_en = 1'b0;
   endtask

   task automatic write_all();
      for (int b = 0; b < BANKS; b++) write_bank(b);
   endtask

   task automatic start_run(input bit lit, input bit wr0);
      for (int l = 0; l < LANES; l++) x_data[l*DW +: DW] = DW'(mx[l]);
      push_expected(lit);
      start = 1'b1;
      if (wr0) begin
         wr_en   = 1'b1;
         wr_bank = '0;
         for (int l = 0; l < LANES; l++) wr_data[l*DW +: DW] = DW'(mw[0][l]);
      end
      @(posedge clk); #1;
      start = 1'b0;
      wr_en = 1'b0;
   endtask

   task automatic wait_empty();
      for (int i = 0; i < 40 && (exp_q.size() != 0 || expt_q.size() != 0); i++) @(negedge clk);
      if (exp_q.size() != 0 || expt_q.size() != 0) begin
         check_val("run_timeout", 32'd1, 32'd0);
         exp_q.delete(); expb_q.delete(); expt_q.delete();
      end
      @(posedge clk); #1;
   endtask

   task automatic set_req035();
      for (int i = 0; i < LANES; i++) begin
         mw[0][i] = i;
         mw[1][i] = 15 - i;
         mw[2][i] = 2 * ((i % 7) + 1);
         mw[3][i] = 2 * (i % 8) + 1;
         mx[i]    = i;
      end
      lit_p = '{1240, 560, 928, 1128};
      lit_t = 3856;
   endtask

   // ---------------- main sequence ----------------
   int d0;
   int e0;

   initial begin
      for (int b = 0; b < BANKS; b++) for (int l = 0; l < LANES; l++) mw[b][l] = 0;
      for (int l = 0; l < LANES; l++) mx[l] = l;

      // reset state
      repeat (2) @(negedge clk);
      check_val("rst_busy",      32'(busy),      32'd0);
      check_val("rst_res_valid", 32'(res_valid), 32'd0);
      check_val("rst_res_data",  32'(res_data),  32'd0);
      check_val("rst_res_bank",  32'(res_bank),  32'd0);
      check_val("rst_done",      32'(done),      32'd0);
      check_val("rst_total",     32'(total),     32'd0);
      check_val("rst_wr_err",    32'(wr_err),    32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // run with no weights written: all partials and total zero
      d0 = done_cnt;
      start_run(1'b0, 1'b0);
      check_val("busy_in_run", 32'(busy), 32'd1);
      wait_empty();
      check_val("done_pulses_zero_run", 32'(done_cnt - d0), 32'd1);

      // reference pattern
      set_req035();
      write_all();
      start_run(1'b1, 1'b0);
      wait_empty();
      repeat (3) @(posedge clk); #1;
      check_val("total_hold", 32'(total), 32'(TW'(lit_t)));
      check_val("busy_idle",  32'(busy),  32'd0);

      // start + write to bank 1 mid-run: both ignored, one wr_err pulse
      e0 = err_cnt;
      d0 = done_cnt;
      start_run(1'b1, 1'b0);
      start   = 1'b1;
      wr_en   = 1'b1;
      wr_bank = BW'(1);
      wr_data = '0;
      @(posedge clk); #1;
      start = 1'b0;
      wr_en = 1'b0;
      wait_empty();
      check_val("wr_err_pulses", 32'(err_cnt - e0), 32'd1);
      check_val("done_pulses_busy_start", 32'(done_cnt - d0), 32'd1);
      start_run(1'b1, 1'b0);
      wait_empty();

      // reset after the second partial: outputs clear, no done
      start_run(1'b1, 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      rst = 1'b1;
      #1;
      check_val("mid_rst_busy",      32'(busy),      32'd0);
      check_val("mid_rst_res_valid", 32'(res_valid), 32'd0);
      check_val("mid_rst_res_data",  32'(res_data),  32'd0);
      check_val("mid_rst_res_bank",  32'(res_bank),  32'd0);
      check_val("mid_rst_total",     32'(total),     32'd0);
      check_val("mid_rst_partials_left", 32'(exp_q.size()), 32'd2);
      exp_q.delete(); expb_q.delete(); expt_q.delete();
      for (int b = 0; b < BANKS; b++) for (int l = 0; l < LANES; l++) mw[b][l] = 0;
      d0 = done_cnt;
      repeat (2) @(posedge clk); #1;
      rst = 1'b0;
      repeat (6) @(posedge clk); #1;
      check_val("no_done_after_rst", 32'(done_cnt - d0), 32'd0);
      start_run(1'b0, 1'b0);
      wait_empty();

`ifdef IMC_SIGNED_EN
      // -1 operands against weight 7
      for (int b = 0; b < BANKS; b++) for (int l = 0; l < LANES; l++) mw[b][l] = 7;
      for (int l = 0; l < LANES; l++) mx[l] = 15;
      lit_p = '{-112, -112, -112, -112};
      lit_t = -448;
`else
      // all-ones operands and weights: largest magnitude, no wrap
      for (int b = 0; b < BANKS; b++) for (int l = 0; l < LANES; l++) mw[b][l] = 15;
      for (int l = 0; l < LANES; l++) mx[l] = 15;
      lit_p = '{3600, 3600, 3600, 3600};
      lit_t = 14400;
`endif
      write_all();
      start_run(1'b1, 1'b0);
      wait_empty();

      // random weights/operands; bank 0 rewritten in the same cycle as start
      for (int it = 0; it < 4; it++) begin
         for (int b = 0; b < BANKS; b++)
            for (int l = 0; l < LANES; l++) mw[b][l] = int'($urandom_range(0, 15));
         for (int l = 0; l < LANES; l++) mx[l] = int'($urandom_range(0, 15));
         write_all();
         for (int l = 0; l < LANES; l++) mw[0][l] = int'($urandom_range(0, 15));
         start_run(1'b0, 1'b1);
         wait_empty();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
      $fatal(1, "watchdog");
   end

endmodule
